// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory controller: FSM state encoding and an
// index-width helper used by the controller and the round-robin arbiter.
package mem_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } state_t;

    // Width of a consumer index; a single consumer still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: starting at ptr_i and wrapping modulo N,
// reports the first asserted request. Shared with the program-memory side.
module rr_arbiter import mem_ctrl_pkg::*; #(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o
);

    // Walk offsets 0..N-1 from the pointer; the lowest offset with a request wins.
    always_comb begin
        int   cand;
        logic hit;
        cand    = 0;
        hit     = 1'b0;
        index_o = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!hit && req_i[cand[IDX_W-1:0]]) begin
                hit     = 1'b1;
                index_o = cand[IDX_W-1:0];
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/mem_controller.sv
// Data-memory controller: funnels NUM_CONSUMERS core read/write ports onto one
// memory port, one transaction at a time, with round-robin consumer selection.
module mem_controller import mem_ctrl_pkg::*; #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    localparam int               IDX_W    = idx_width(NUM_CONSUMERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

    state_t                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         rr_ptr_q;
    logic [IDX_W-1:0]         rr_ptr_d;
    logic [NUM_CONSUMERS-1:0] rd_ready_q;
    logic [NUM_CONSUMERS-1:0] wr_ready_q;
    logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];

    logic [ADDR_BITS-1:0]     rd_addr_arr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     wr_addr_arr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     wr_data_arr [NUM_CONSUMERS];

    logic [NUM_CONSUMERS-1:0] req_vec;
    logic                     arb_found;
    logic [IDX_W-1:0]         arb_idx;

    // Unpack the flat consumer buses and repack the registered read data.
    generate
        for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_port
            assign rd_addr_arr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
            assign wr_addr_arr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
            assign wr_data_arr[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
            assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = rd_data_q[gi];
        end
    endgenerate

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_write_ready = wr_ready_q;

    // A consumer competes if it has either kind of request pending.
    assign req_vec = consumer_read_valid | consumer_write_valid;

    // After finishing consumer idx_q, the next scan starts just past it.
    assign rr_ptr_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    rr_arbiter #(
        .N     (NUM_CONSUMERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (req_vec),
        .ptr_i   (rr_ptr_q),
        .found_o (arb_found),
        .index_o (arb_idx)
    );

    // Transaction FSM; every memory-side and consumer-side output is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            rr_ptr_q          <= '0;
            rd_ready_q        <= '0;
            wr_ready_q        <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        idx_q <= arb_idx;
                        // A consumer asking for both is served its read first.
                        if (consumer_read_valid[arb_idx]) begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= rd_addr_arr[arb_idx];
                            state_q          <= READ_WAIT;
                        end else begin
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= wr_addr_arr[arb_idx];
                            mem_write_data    <= wr_data_arr[arb_idx];
                            state_q           <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_read_valid    <= 1'b0;
                        rd_ready_q[idx_q] <= 1'b1;
                        rd_data_q[idx_q]  <= mem_read_data;
                        state_q           <= READ_RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        mem_write_valid   <= 1'b0;
                        wr_ready_q[idx_q] <= 1'b1;
                        state_q           <= WRITE_RELAY;
                    end
                end
                READ_RELAY: begin
                    if (!consumer_read_valid[idx_q]) begin
                        rd_ready_q[idx_q] <= 1'b0;
                        rr_ptr_q          <= rr_ptr_d;
                        state_q           <= IDLE;
                    end
                end
                WRITE_RELAY: begin
                    if (!consumer_write_valid[idx_q]) begin
                        wr_ready_q[idx_q] <= 1'b0;
                        rr_ptr_q          <= rr_ptr_d;
                        state_q           <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: a table of single transactions followed
// by hand-written round-robin, read-over-write, stall and reset sequences.
module tb_mem_controller;

    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    consumer_read_valid;
    logic [N*AB-1:0] consumer_read_address;
    logic [N-1:0]    consumer_read_ready;
    logic [N*DB-1:0] consumer_read_data;
    logic [N-1:0]    consumer_write_valid;
    logic [N*AB-1:0] consumer_write_address;
    logic [N*DB-1:0] consumer_write_data;
    logic [N-1:0]    consumer_write_ready;
    logic            mem_read_valid;
    logic [AB-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DB-1:0]   mem_read_data;
    logic            mem_write_valid;
    logic [AB-1:0]   mem_write_address;
    logic [DB-1:0]   mem_write_data;
    logic            mem_write_ready;

    always #5 clk = ~clk;

    mem_controller #(
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .NUM_CONSUMERS (N)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         core;
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         waits;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] exp_rd_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction from the table, checked cycle by cycle.
    task automatic run_vec(input vec_t v);
        logic [3:0] oh;
        oh = 4'b0001 << v.core;
        if (v.is_wr) begin
            consumer_write_valid[v.core] = 1'b1;
            consumer_write_address[v.core*AB +: AB] = v.addr;
            consumer_write_data[v.core*DB +: DB] = v.wdata;
        end else begin
            consumer_read_valid[v.core] = 1'b1;
            consumer_read_address[v.core*AB +: AB] = v.addr;
        end
        tick();
        if (v.is_wr) begin
            chk("wr_req_valid", mem_write_valid, 1);
            chk("wr_req_addr", mem_write_address, v.exp_addr);
            chk("wr_req_data", mem_write_data, v.exp_data);
            chk("wr_no_rd_valid", mem_read_valid, 0);
        end else begin
            chk("rd_req_valid", mem_read_valid, 1);
            chk("rd_req_addr", mem_read_address, v.exp_addr);
            chk("rd_no_wr_valid", mem_write_valid, 0);
        end
        for (int w = 0; w < v.waits; w++) begin
            tick();
            chk("wait_valid", v.is_wr ? mem_write_valid : mem_read_valid, 1);
            chk("wait_no_ready", {consumer_read_ready, consumer_write_ready}, 0);
        end
        if (v.is_wr) begin
            mem_write_ready = 1'b1;
        end else begin
            mem_read_ready = 1'b1;
            mem_read_data  = v.rdata;
        end
        tick();
        mem_write_ready = 1'b0;
        mem_read_ready  = 1'b0;
        mem_read_data   = 8'h00;
        if (v.is_wr) begin
            chk("wr_done_valid", mem_write_valid, 0);
            chk("wr_ready", consumer_write_ready, oh);
            chk("wr_no_rd_ready", consumer_read_ready, 0);
        end else begin
            exp_rd_vec[v.core*DB +: DB] = v.exp_data;
            chk("rd_done_valid", mem_read_valid, 0);
            chk("rd_ready", consumer_read_ready, oh);
            chk("rd_data", consumer_read_data, exp_rd_vec);
            chk("rd_no_wr_ready", consumer_write_ready, 0);
        end
        tick();
        chk("relay_hold", v.is_wr ? consumer_write_ready : consumer_read_ready, oh);
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        tick();
        chk("relay_drop", {consumer_read_ready, consumer_write_ready}, 0);
        chk("rd_data_kept", consumer_read_data, exp_rd_vec);
    endtask

    // Wait (bounded) for a memory read, answer it, and release the granted core.
    task automatic serve_read(input int core, input logic [7:0] exp_addr, input logic [7:0] data);
        int n;
        n = 0;
        while (!mem_read_valid && n < 10) begin
            tick();
            n++;
        end
        chk("grant_rd_valid", mem_read_valid, 1);
        chk("grant_rd_addr", mem_read_address, exp_addr);
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = 8'h00;
        chk("grant_rd_ready", consumer_read_ready, 32'(4'b0001 << core));
        chk("grant_rd_data", consumer_read_data[core*DB +: DB], data);
        consumer_read_valid[core] = 1'b0;
        tick();
        chk("grant_rd_release", consumer_read_ready, 0);
    endtask

    task automatic serve_write(input int core, input logic [7:0] exp_addr, input logic [7:0] exp_data);
        int n;
        n = 0;
        while (!mem_write_valid && n < 10) begin
            tick();
            n++;
        end
        chk("grant_wr_valid", mem_write_valid, 1);
        chk("grant_wr_addr", mem_write_address, exp_addr);
        chk("grant_wr_data", mem_write_data, exp_data);
        chk("grant_wr_no_rd", mem_read_valid, 0);
        mem_write_ready = 1'b1;
        tick();
        mem_write_ready = 1'b0;
        chk("grant_wr_ready", consumer_write_ready, 32'(4'b0001 << core));
        consumer_write_valid[core] = 1'b0;
        tick();
        chk("grant_wr_release", consumer_write_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{core: 1, is_wr: 1'b0, addr: 8'h10, wdata: 8'h00, rdata: 8'hA5, waits: 2, exp_addr: 8'h10, exp_data: 8'hA5};
        vecs[1] = '{core: 2, is_wr: 1'b1, addr: 8'h22, wdata: 8'h3C, rdata: 8'h00, waits: 0, exp_addr: 8'h22, exp_data: 8'h3C};
        vecs[2] = '{core: 0, is_wr: 1'b0, addr: 8'h7F, wdata: 8'h00, rdata: 8'h5A, waits: 0, exp_addr: 8'h7F, exp_data: 8'h5A};
        vecs[3] = '{core: 3, is_wr: 1'b1, addr: 8'hFF, wdata: 8'h81, rdata: 8'h00, waits: 1, exp_addr: 8'hFF, exp_data: 8'h81};
        vecs[4] = '{core: 3, is_wr: 1'b0, addr: 8'h00, wdata: 8'h00, rdata: 8'hFF, waits: 3, exp_addr: 8'h00, exp_data: 8'hFF};

        reset                  = 1'b1;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b0;
        mem_read_data          = '0;
        mem_write_ready        = 1'b0;
        exp_rd_vec             = '0;
        tick();
        tick();
        chk("rst_mem_valid", {mem_read_valid, mem_write_valid}, 0);
        chk("rst_mem_addr", {mem_read_address, mem_write_address, mem_write_data}, 0);
        chk("rst_ready", {consumer_read_ready, consumer_write_ready}, 0);
        chk("rst_rd_data", consumer_read_data, 0);
        reset = 1'b0;
        tick();

        // Table of isolated transactions; the last one (core 3) wraps rr_ptr to 0.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            $display("vector %0d core=%0d wr=%0d addr=0x%0h done", i, vecs[i].core, vecs[i].is_wr, vecs[i].addr);
        end

        // All four cores read at once; core 0 re-requests right after its turn.
        consumer_read_valid = 4'hF;
        for (int i = 0; i < N; i++) begin
            consumer_read_address[i*AB +: AB] = 8'h40 + 8'(i);
        end
        serve_read(0, 8'h40, 8'hC0);
        consumer_read_valid[0] = 1'b1;
        consumer_read_address[0*AB +: AB] = 8'h50;
        serve_read(1, 8'h41, 8'hC1);
        serve_read(2, 8'h42, 8'hC2);
        serve_read(3, 8'h43, 8'hC3);
        serve_read(0, 8'h50, 8'hD0);
        $display("round-robin sequence done");

        // Core 0 asks for read and write together: read first, write next.
        consumer_read_valid[0] = 1'b1;
        consumer_read_address[0*AB +: AB] = 8'h01;
        consumer_write_valid[0] = 1'b1;
        consumer_write_address[0*AB +: AB] = 8'h02;
        consumer_write_data[0*DB +: DB] = 8'h77;
        tick();
        chk("row_read_first", {mem_read_valid, mem_write_valid}, 2'b10);
        serve_read(0, 8'h01, 8'h11);
        serve_write(0, 8'h02, 8'h77);
        $display("read-over-write sequence done");

        // Core 2 write moves rr_ptr to 3 so the post-reset grant shows the pointer cleared.
        consumer_write_valid[2] = 1'b1;
        consumer_write_address[2*AB +: AB] = 8'h44;
        consumer_write_data[2*DB +: DB] = 8'h99;
        serve_write(2, 8'h44, 8'h99);

        // Stalled read: request must stay stable; stray write-ready is ignored.
        consumer_read_valid[2] = 1'b1;
        consumer_read_address[2*AB +: AB] = 8'h33;
        tick();
        for (int c = 0; c < 20; c++) begin
            mem_write_ready = (c >= 5 && c < 10);
            chk("stall_valid", mem_read_valid, 1);
            chk("stall_addr", mem_read_address, 8'h33);
            chk("stall_no_ready", {consumer_read_ready, consumer_write_ready, mem_write_valid}, 0);
            tick();
        end
        mem_write_ready = 1'b0;
        $display("stall sequence done");

        // Reset during READ_WAIT abandons the request and returns no ready.
        reset = 1'b1;
        consumer_read_valid = '0;
        tick();
        chk("midrst_valid", {mem_read_valid, mem_write_valid}, 0);
        chk("midrst_ready", {consumer_read_ready, consumer_write_ready}, 0);
        chk("midrst_rd_data", consumer_read_data, 0);
        reset = 1'b0;
        tick();
        chk("postrst_idle", {mem_read_valid, consumer_read_ready}, 0);

        // Cores 1 and 3 together: rr_ptr back at 0 means core 1 goes first.
        consumer_read_valid[1] = 1'b1;
        consumer_read_address[1*AB +: AB] = 8'h61;
        consumer_read_valid[3] = 1'b1;
        consumer_read_address[3*AB +: AB] = 8'h63;
        serve_read(1, 8'h61, 8'hE1);
        serve_read(3, 8'h63, 8'hE3);
        $display("post-reset sequence done");

        // Memory ready with no request outstanding does nothing.
        mem_read_ready  = 1'b1;
        mem_write_ready = 1'b1;
        tick();
        tick();
        chk("idle_mem_ready", {mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready}, 0);
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
Arbitrates the data-memory read/write requests of NUM_CONSUMERS compute cores onto one external data-memory port. It sits directly downstream of each core's data_mem_read/write valid/ready interface and presents a single valid/ready master port to data memory. One transaction is serviced at a time, and consumers are selected by a round-robin grant.

Parameters:
- ADDR_BITS, 8, data-memory address width; matches the core's DATA_MEM_ADDR_BITS.
- DATA_BITS, 8, data word width; matches the core's DATA_MEM_DATA_BITS.
- NUM_CONSUMERS, 4, number of core request ports; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-core read request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; core i occupies slice [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  read done; data valid while high.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data.
- consumer_write_valid  in  NUM_CONSUMERS  per-core write request.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed.
- consumer_write_ready  out  NUM_CONSUMERS  write done.
- mem_read_valid  out  1  read request to memory.
- mem_read_address  out  ADDR_BITS  read address to memory.
- mem_read_ready  in  1  memory read complete; mem_read_data valid in the same cycle.
- mem_read_data  in  DATA_BITS  read data from memory.
- mem_write_valid  out  1  write request to memory.
- mem_write_address  out  ADDR_BITS  write address to memory.
- mem_write_data  out  DATA_BITS  write data to memory.
- mem_write_ready  in  1  memory write accepted.

Behaviour:
- Reset: all outputs are registered and reset to 0. State = IDLE, rr_ptr = 0, grant index = 0.
- FSM states:
  - IDLE: scan consumers rr_ptr, rr_ptr+1, … (mod N). The first index with read_valid or write_valid wins. If that consumer has both, the read wins.
    - Read winner: latch index and address; next cycle mem_read_valid=1; go READ_WAIT.
    - Write winner: latch index, address and data; next cycle mem_write_valid=1; go WRITE_WAIT.
    - No request: stay in IDLE.
  - READ_WAIT: hold mem_read_valid and mem_read_address stable until mem_read_ready=1. In that cycle capture mem_read_data. Next cycle: mem_read_valid=0, consumer_read_ready[i]=1, consumer_read_data[i]=captured data; go READ_RELAY.
  - WRITE_WAIT: hold mem_write_* until mem_write_ready=1. Next cycle: mem_write_valid=0, consumer_write_ready[i]=1; go WRITE_RELAY.
  - READ_RELAY / WRITE_RELAY: hold ready[i] high while consumer valid[i] stays high. Once valid[i] is sampled low: next cycle ready[i]=0, rr_ptr=(i+1) mod N, go IDLE.
- Latency: request sampled in IDLE at cycle 0 → mem valid at cycle 1. Memory ready at cycle k → consumer ready at cycle k+1. Minimum IDLE-to-IDLE for a 0-wait memory is 4 cycles.
- consumer_read_data[i] holds its last value after ready drops; its reset value is 0. Ready/data of non-granted consumers stay 0 / unchanged.
- Request changes while granted: latched address/data are used; consumer changes mid-transaction are ignored.
- Consumer drops valid before ready (protocol violation): the transaction still completes. The relay state then exits after one ready cycle.
- Memory ready asserted while the corresponding valid=0: ignored.
- rr_ptr wraps from N-1 to 0. With N=1 the pointer is always 0.
- Reset mid-transaction: the memory request is abandoned immediately (valid=0 on the next edge). No ready is returned to the consumer.

Decomposition:
- Package mem_ctrl_pkg holds:
  - typedef enum of states (IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY);
  - the 3-bit state-width constant.
- Sub-module rr_arbiter (parameter N): inputs request vector and rr_ptr; outputs found and index. Purely combinational, reusable by the program-memory controller.

Test Plan:
- Single read: core1 read addr 0x10, memory returns 0xA5 after 2 wait cycles → mem_read_address=0x10. consumer_read_ready[1] rises 1 cycle after mem_read_ready, with consumer_read_data[1]=0xA5. It drops 1 cycle after core1 drops valid.
- Single write: core2 writes 0x3C to 0x22, memory ready after 0 wait → mem_write_address=0x22 and mem_write_data=0x3C for exactly 1 cycle. consumer_write_ready[2] pulses; no mem_read_valid is ever asserted.
- Round-robin: cores 0–3 all request reads simultaneously and hold → grant order 0,1,2,3. A core 0 re-request after its completion is served only after core 3.
- Read-over-write: core0 asserts read 0x01 and write 0x02 together → read serviced first, then the write in the following transaction.
- Reset mid-op: assert reset during READ_WAIT → next cycle mem_read_valid=0, all ready=0, rr_ptr=0. After reset, a core3 request is served normally.
- Stall: memory withholds ready for 20 cycles → mem_read_valid and address remain stable throughout; no consumer ready is asserted.
